c3po_egress_arb: RTL and testbench

- Packet-level round-robin arbiter that merges the PORTS_P per-port unpacker output streams (32-byte beats) onto one shared egress bus.
- Once a port wins, its grant is locked from sop to eop, so packets never interleave.
- The output stage is registered with a valid/ready handshake, so the downstream sink can apply backpressure.
- Sits directly after the c3po slice array, between the unpackers and the egress interface.

---
 rtl/c3po_arb_pkg.sv | 20 ++
 rtl/c3po_rr_pick.sv | 33 +++
 rtl/c3po_egress_arb.sv | 178 +++++++++++++++++
 tb/tb_c3po_egress_arb.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c3po_arb_pkg.sv
// Shared types and constants for the c3po egress arbiter.
package c3po_arb_pkg;

    localparam int PORTS_C  = 4;
    localparam int DATA_W_C = 256;
    localparam int PORT_W   = $clog2(PORTS_C);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic                sop;
        logic                eop;
        logic [7:0]          vbc;
        logic [DATA_W_C-1:0] data;
    } beat_t;

endpackage

// File: rtl/c3po_rr_pick.sv
// Combinational rotate-priority picker: first requester after ptr_i wins.
module c3po_rr_pick #(
    parameter int PORTS_P  = 4,
    parameter int PORT_W_P = $clog2(PORTS_P)
) (
    input  logic [PORTS_P-1:0]  req_i,
    input  logic [PORT_W_P-1:0] ptr_i,
    output logic                any_o,
    output logic [PORT_W_P-1:0] idx_o
);

    int                  j;
    logic [PORT_W_P-1:0] cand;

    // Walk from the farthest slot to the nearest so the nearest requester overwrites last.
    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        j     = 0;
        cand  = '0;
        for (int k = PORTS_P; k >= 1; k--) begin
            j    = (int'(ptr_i) + k) % PORTS_P;
            cand = j[PORT_W_P-1:0];
            if (req_i[cand]) begin
                any_o = 1'b1;
                idx_o = cand;
            end else begin
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/c3po_egress_arb.sv
// Packet-locked round-robin merge of the unpacker streams onto one egress bus.
// Define C3PO_ARB_STATS_EN to add per-port accepted-packet counters (pkt_cnt).
module c3po_egress_arb
    import c3po_arb_pkg::*;
#(
    parameter int PORTS_P    = 4,
    parameter int DATA_W     = 256,
    parameter int CNT_SIZE_P = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [PORTS_P-1:0]                    cfg_port_enable,
    input  logic [PORTS_P-1:0]                    in_val,
    input  logic [PORTS_P-1:0]                    in_sop,
    input  logic [PORTS_P-1:0]                    in_eop,
    input  logic [PORTS_P*8-1:0]                  in_vbc,
    input  logic [PORTS_P*DATA_W-1:0]             in_data,
    output logic [PORTS_P-1:0]                    in_ready,
    output logic                                  out_val,
    output logic                                  out_sop,
    output logic                                  out_eop,
    output logic [7:0]                            out_vbc,
    output logic [DATA_W-1:0]                     out_data,
    output logic [((PORTS_P > 1) ? $clog2(PORTS_P) : 1)-1:0] out_port,
    input  logic                                  out_ready,
    output logic                                  busy
`ifdef C3PO_ARB_STATS_EN
    ,
    output logic [PORTS_P*CNT_SIZE_P-1:0]         pkt_cnt
`endif
);

    localparam int PORT_W_L = (PORTS_P > 1) ? $clog2(PORTS_P) : 1;
    localparam int VBC_W    = 8;

    if (PORTS_P < 2 || PORTS_P > 16 || CNT_SIZE_P < 1) begin : g_bad_param
        $error("c3po_egress_arb: unsupported parameter set");
    end

    state_e                state_q, state_d;
    logic [PORT_W_L-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PORT_W_L-1:0]   gnt_q, gnt_d;
    logic                  out_val_d, out_sop_d, out_eop_d;
    logic [VBC_W-1:0]      out_vbc_d;
    logic [DATA_W-1:0]     out_data_d;
    logic [PORT_W_L-1:0]   out_port_d;
    logic [PORTS_P-1:0]    req_s;
    logic                  pick_any_s;
    logic [PORT_W_L-1:0]   pick_idx_s;
    logic                  out_free_s, accept_s, accept_eop_s;

    // cfg_port_enable only matters here, so a mid-packet disable never aborts a packet.
    assign req_s        = in_val & in_sop & cfg_port_enable;
    assign out_free_s   = ~out_val | out_ready;
    assign accept_s     = (state_q == BUSY) & in_val[gnt_q] & out_free_s;
    assign accept_eop_s = accept_s & in_eop[gnt_q];
    assign busy         = (state_q == BUSY);

    c3po_rr_pick #(
        .PORTS_P  (PORTS_P),
        .PORT_W_P (PORT_W_L)
    ) u_pick (
        .req_i (req_s),
        .ptr_i (rr_ptr_q),
        .any_o (pick_any_s),
        .idx_o (pick_idx_s)
    );

    // Only the locked port may be accepted, and only when the output slot frees up.
    always_comb begin
        in_ready = '0;
        if (state_q == BUSY) begin
            in_ready[gnt_q] = out_free_s;
        end else begin
            in_ready = '0;
        end
    end

    // Grant FSM: arbitrate in IDLE, hold the grant until the eop beat is accepted.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        case (state_q)
            IDLE: begin
                if (pick_any_s) begin
                    state_d  = BUSY;
                    gnt_d    = pick_idx_s;
                    rr_ptr_d = pick_idx_s;
                end else begin
                    state_d  = IDLE;
                end
            end
            BUSY: begin
                if (accept_eop_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = BUSY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output slot: load on accept, drain when consumed, otherwise hold.
    always_comb begin
        out_val_d  = out_val;
        out_sop_d  = out_sop;
        out_eop_d  = out_eop;
        out_vbc_d  = out_vbc;
        out_data_d = out_data;
        out_port_d = out_port;
        if (accept_s) begin
            out_val_d  = 1'b1;
            out_sop_d  = in_sop[gnt_q];
            out_eop_d  = in_eop[gnt_q];
            out_vbc_d  = in_vbc[int'(gnt_q) * VBC_W +: VBC_W];
            out_data_d = in_data[int'(gnt_q) * DATA_W +: DATA_W];
            out_port_d = gnt_q;
        end else if (out_free_s) begin
            out_val_d  = 1'b0;
        end else begin
            out_val_d  = out_val;
        end
    end

    // State, pointer and output registers; rr_ptr resets to the last port so port 0 leads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= PORT_W_L'(PORTS_P - 1);
            gnt_q    <= '0;
            out_val  <= 1'b0;
            out_sop  <= 1'b0;
            out_eop  <= 1'b0;
            out_vbc  <= '0;
            out_data <= '0;
            out_port <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            out_val  <= out_val_d;
            out_sop  <= out_sop_d;
            out_eop  <= out_eop_d;
            out_vbc  <= out_vbc_d;
            out_data <= out_data_d;
            out_port <= out_port_d;
        end
    end

`ifdef C3PO_ARB_STATS_EN
    logic [PORTS_P*CNT_SIZE_P-1:0] pkt_cnt_q, pkt_cnt_d;

    // Count accepted eop beats per source port; counters wrap naturally.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (accept_eop_s) begin
            pkt_cnt_d[int'(gnt_q) * CNT_SIZE_P +: CNT_SIZE_P] =
                pkt_cnt_q[int'(gnt_q) * CNT_SIZE_P +: CNT_SIZE_P] + CNT_SIZE_P'(1);
        end else begin
            pkt_cnt_d = pkt_cnt_q;
        end
    end

    // Packet counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_c3po_egress_arb.sv
// Directed bench for c3po_egress_arb: per-port source queues plus an egress scoreboard.
module tb_c3po_egress_arb;

    typedef logic [279:0] cv_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   cfg_port_enable, in_val, in_sop, in_eop, in_ready;
    logic [31:0]  in_vbc;
    logic [1023:0] in_data;
    logic         out_val, out_sop, out_eop, out_ready, busy;
    logic [7:0]   out_vbc;
    logic [255:0] out_data;
    logic [1:0]   out_port;
`ifdef C3PO_ARB_STATS_EN
    logic [31:0]  pkt_cnt;
`endif

    always #5 clk = ~clk;

    c3po_egress_arb #(.PORTS_P(4), .DATA_W(256), .CNT_SIZE_P(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .cfg_port_enable (cfg_port_enable),
        .in_val          (in_val),
        .in_sop          (in_sop),
        .in_eop          (in_eop),
        .in_vbc          (in_vbc),
        .in_data         (in_data),
        .in_ready        (in_ready),
        .out_val         (out_val),
        .out_sop         (out_sop),
        .out_eop         (out_eop),
        .out_vbc         (out_vbc),
        .out_data        (out_data),
        .out_port        (out_port),
        .out_ready       (out_ready),
        .busy            (busy)
`ifdef C3PO_ARB_STATS_EN
        ,
        .pkt_cnt         (pkt_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_extra = 0;
    int serial  = 0;

    logic [265:0] src_q [4][$];
    logic [273:0] exp_q [$];

    logic         s_val, s_sop, s_eop, s_busy;
    logic [7:0]   s_vbc;
    logic [1:0]   s_port;
    logic [255:0] s_data;
    logic [3:0]   s_rdy, acc, acc_eop;

    task automatic chk(input string tag, input cv_t got, input cv_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_pkt(input int p, input int nb, input logic [7:0] last_vbc, input bit expect_out);
        logic [265:0] b;
        for (int k = 0; k < nb; k++) begin
            serial++;
            b[265]     = (k == 0);
            b[264]     = (k == nb - 1);
            b[263:256] = (k == nb - 1) ? last_vbc : 8'd32;
            b[255:0]   = {8{p[3:0], serial[27:0]}};
            src_q[p].push_back(b);
            if (expect_out) exp_q.push_back({p[7:0], b});
        end
    endtask

    task automatic present();
        for (int p = 0; p < 4; p++) begin
            if (src_q[p].size() > 0) begin
                in_val[p]              = 1'b1;
                in_sop[p]              = src_q[p][0][265];
                in_eop[p]              = src_q[p][0][264];
                in_vbc[p*8 +: 8]       = src_q[p][0][263:256];
                in_data[p*256 +: 256]  = src_q[p][0][255:0];
            end else begin
                in_val[p]              = 1'b0;
                in_sop[p]              = 1'b0;
                in_eop[p]              = 1'b0;
                in_vbc[p*8 +: 8]       = 8'd0;
                in_data[p*256 +: 256]  = 256'd0;
            end
        end
    endtask

    // One clock: sample at negedge, score egress handshakes, then advance sources.
    task automatic cyc();
        @(negedge clk);
        s_val = out_val; s_sop = out_sop; s_eop = out_eop; s_vbc = out_vbc;
        s_port = out_port; s_data = out_data; s_rdy = in_ready; s_busy = busy;
        acc     = in_val & in_ready;
        acc_eop = acc & in_eop;
        if (out_val && out_ready) begin
            if (exp_q.size() == 0) n_extra++;
            else chk("sb_beat", cv_t'({6'd0, out_port, out_sop, out_eop, out_vbc, out_data}),
                     cv_t'(exp_q.pop_front()));
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < 4; p++) begin
            if (acc[p]) void'(src_q[p].pop_front());
        end
        present();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int p = 0; p < 4; p++) src_q[p].delete();
        exp_q.delete();
        present();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [266:0] snap;
        bit done1;
        reset = 1'b1;
        cfg_port_enable = 4'hF;
        out_ready = 1'b1;
        in_val = 4'd0; in_sop = 4'd0; in_eop = 4'd0; in_vbc = 32'd0; in_data = 1024'd0;
        present();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_val",  cv_t'(out_val),  cv_t'(1'b0));
        chk("rst_out_vbc",  cv_t'(out_vbc),  cv_t'(8'd0));
        chk("rst_out_data", cv_t'(out_data), cv_t'(256'd0));
        chk("rst_out_port", cv_t'(out_port), cv_t'(2'd0));
        chk("rst_in_ready", cv_t'(in_ready), cv_t'(4'd0));
        chk("rst_busy",     cv_t'(busy),     cv_t'(1'b0));
        reset = 1'b0;

        // Single port, 3-beat packet.
        push_pkt(0, 3, 8'd5, 1'b1);
        present();
        cyc();
        chk("t1_c0_busy", cv_t'(s_busy), cv_t'(1'b0));
        chk("t1_c0_rdy",  cv_t'(s_rdy),  cv_t'(4'b0000));
        cyc();
        chk("t1_c1_busy", cv_t'(s_busy), cv_t'(1'b1));
        chk("t1_c1_rdy",  cv_t'(s_rdy),  cv_t'(4'b0001));
        chk("t1_c1_val",  cv_t'(s_val),  cv_t'(1'b0));
        cyc();
        chk("t1_c2_beat", cv_t'({s_val, s_sop, s_eop, s_vbc, s_port}), cv_t'({1'b1, 1'b1, 1'b0, 8'd32, 2'd0}));
        cyc();
        chk("t1_c3_beat", cv_t'({s_val, s_sop, s_eop, s_vbc}), cv_t'({1'b1, 1'b0, 1'b0, 8'd32}));
        cyc();
        chk("t1_c4_beat", cv_t'({s_val, s_sop, s_eop, s_vbc, s_port}), cv_t'({1'b1, 1'b0, 1'b1, 8'd5, 2'd0}));
        chk("t1_c4_busy", cv_t'(s_busy), cv_t'(1'b0));
        cyc();
        chk("t1_c5_val",  cv_t'(s_val),  cv_t'(1'b0));
        chk("t1_drain",   cv_t'(exp_q.size()), cv_t'(0));

        // Fairness: every port keeps one-beat packets queued.
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < 4; p++) push_pkt(p, 1, 8'(p + 1), 1'b1);
        present();
        for (int k = 0; k < 18; k++) begin
            cyc();
            if (k >= 2) chk("fair_val", cv_t'(s_val), cv_t'((k % 2 == 0) && (k <= 16)));
        end
        chk("fair_drain", cv_t'(exp_q.size()), cv_t'(0));

        // Packet lock with port 2 also requesting: order 1, 2, 0.
        push_pkt(1, 3, 8'd7, 1'b1);
        present();
        done1 = 1'b0;
        for (int k = 0; k < 14; k++) begin
            if (k == 2) begin
                push_pkt(2, 1, 8'd2, 1'b1);
                push_pkt(0, 1, 8'd1, 1'b1);
                present();
            end
            cyc();
            if (!done1) chk("lock_rdy0", cv_t'(s_rdy[0]), cv_t'(1'b0));
            if (acc_eop[1]) done1 = 1'b1;
        end
        chk("lockA_drain", cv_t'(exp_q.size()), cv_t'(0));

        // Packet lock without port 2: order 1, 0.
        push_pkt(1, 2, 8'd9, 1'b1);
        present();
        for (int k = 0; k < 10; k++) begin
            if (k == 1) begin
                push_pkt(0, 1, 8'd8, 1'b1);
                present();
            end
            cyc();
        end
        chk("lockB_drain", cv_t'(exp_q.size()), cv_t'(0));

        // Backpressure: 5 stalled cycles mid-packet.
        push_pkt(3, 4, 8'd11, 1'b1);
        present();
        cyc();
        cyc();
        out_ready = 1'b0;
        cyc();
        snap = {s_val, s_sop, s_eop, s_vbc, s_data};
        chk("bp_val", cv_t'(s_val), cv_t'(1'b1));
        chk("bp_rdy", cv_t'(s_rdy[3]), cv_t'(1'b0));
        for (int k = 3; k < 7; k++) begin
            cyc();
            chk("bp_hold", cv_t'({s_val, s_sop, s_eop, s_vbc, s_data}), cv_t'(snap));
            chk("bp_rdy",  cv_t'(s_rdy[3]), cv_t'(1'b0));
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) cyc();
        chk("bp_drain", cv_t'(exp_q.size()), cv_t'(0));

        // Enable: port 2 disabled throughout, port 1 disabled mid-packet.
        do_reset();
        cfg_port_enable = 4'b1011;
        push_pkt(1, 3, 8'd13, 1'b1);
        push_pkt(2, 1, 8'd3, 1'b0);
        push_pkt(3, 1, 8'd4, 1'b1);
        present();
        for (int k = 0; k < 14; k++) begin
            if (k == 2) cfg_port_enable = 4'b1001;
            cyc();
            chk("en_rdy2", cv_t'(s_rdy[2]), cv_t'(1'b0));
        end
        chk("en_left2", cv_t'(src_q[2].size()), cv_t'(1));
        chk("en_drain", cv_t'(exp_q.size()), cv_t'(0));

        // Reset mid-packet.
        do_reset();
        cfg_port_enable = 4'hF;
        push_pkt(1, 4, 8'd15, 1'b1);
        present();
        cyc();
        cyc();
        cyc();
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_val",  cv_t'(out_val),  cv_t'(1'b0));
        chk("mid_rst_vbc",  cv_t'(out_vbc),  cv_t'(8'd0));
        chk("mid_rst_data", cv_t'(out_data), cv_t'(256'd0));
        chk("mid_rst_port", cv_t'(out_port), cv_t'(2'd0));
        chk("mid_rst_rdy",  cv_t'(in_ready), cv_t'(4'd0));
        chk("mid_rst_busy", cv_t'(busy),     cv_t'(1'b0));
        for (int p = 0; p < 4; p++) src_q[p].delete();
        exp_q.delete();
        push_pkt(0, 1, 8'd17, 1'b1);
        push_pkt(1, 1, 8'd18, 1'b1);
        present();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc();
        cyc();
        chk("rst_first_gnt", cv_t'(s_rdy), cv_t'(4'b0001));
        for (int k = 0; k < 6; k++) cyc();
        chk("rst_drain", cv_t'(exp_q.size()), cv_t'(0));

`ifdef C3PO_ARB_STATS_EN
        // Counter wrap: 257 packets from port 3.
        do_reset();
        chk("stats_rst", cv_t'(pkt_cnt), cv_t'(32'd0));
        for (int n = 0; n < 257; n++) push_pkt(3, 1, 8'd1, 1'b1);
        present();
        for (int k = 0; k < 700 && exp_q.size() > 0; k++) cyc();
        repeat (2) cyc();
        chk("stats_drain", cv_t'(exp_q.size()), cv_t'(0));
        chk("stats_cnt3",  cv_t'(pkt_cnt[31:24]), cv_t'(8'd1));
        chk("stats_cnt0",  cv_t'(pkt_cnt[7:0]),   cv_t'(8'd0));
`endif

        chk("sb_extra", cv_t'(n_extra), cv_t'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
